// File: rtl/ram_loader_if.sv
// CPU bus and boot-loader stream for ram_loader, bundled so both sides share one widths declaration.
// Handshake: a loader word moves on any rising edge where load_valid && load_ready; load_data/load_last must be stable while load_valid is high.
interface ram_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  we;
  logic                  oe;
  logic                  load_valid;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  load_ready;
  logic                  cpu_hold;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;

  modport master (
    output addr, data_in, we, oe, load_valid, load_data, load_last,
    input  data_out, load_ready, cpu_hold, out_data, out_valid
  );

  modport slave (
    input  addr, data_in, we, oe, load_valid, load_data, load_last,
    output data_out, load_ready, cpu_hold, out_data, out_valid
  );
endinterface

// File: rtl/ram_loader.sv
// Word-addressed RAM with a boot loader that fills memory while the CPU is held,
// plus an optional memory-mapped output register.
module ram_loader #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    READ_REG   = 0,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR   = {ADDR_WIDTH{1'b1}},
  parameter bit                    OUT_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  ram_loader_if.slave           bus,
  output logic                  fsm_state,
  output logic [ADDR_WIDTH-1:0] load_ptr
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] LOAD = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_src;
  logic                  load_xfer;
  logic                  ptr_at_end;
  logic                  out_hit;
  logic                  cpu_wr;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign load_xfer  = (state == LOAD) && bus.load_valid;
  assign ptr_at_end = (load_ptr == {ADDR_WIDTH{1'b1}});
  assign out_hit    = OUT_EN && (bus.addr == OUT_ADDR);
  assign cpu_wr     = (state == RUN) && bus.we;

  // Loader and CPU never write in the same state, so one shared write port suffices.
  assign mem_we    = !reset && (load_xfer || (cpu_wr && !out_hit));
  assign mem_addr  = (state == LOAD) ? load_ptr : bus.addr;
  assign mem_wdata = (state == LOAD) ? bus.load_data : bus.data_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      load_ptr    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (load_xfer) begin
        if (bus.load_last || ptr_at_end)
          state <= RUN;
        // The pointer parks on the last word rather than wrapping to zero.
        if (!ptr_at_end)
          load_ptr <= load_ptr + 1'b1;
      end
      if (cpu_wr && out_hit) begin
        out_data_q  <= bus.data_in;
        out_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_addr] <= mem_wdata;
  end

  assign rd_src = out_hit ? out_data_q : mem[bus.addr];

  generate
    if (READ_REG != 0) begin : g_read_reg
      // Samples the source before this edge's write lands: read-before-write.
      always_ff @(posedge clk) begin
        if (reset)
          rd_data <= '0;
        else if ((state == RUN) && bus.oe)
          rd_data <= rd_src;
        else
          rd_data <= '0;
      end
    end else begin : g_read_comb
      always_comb begin
        rd_data = '0;
        if ((state == RUN) && bus.oe)
          rd_data = rd_src;
      end
    end
  endgenerate

  assign bus.data_out   = rd_data;
  assign bus.load_ready = (state == LOAD);
  assign bus.cpu_hold   = (state == LOAD);
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign fsm_state      = state;
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: one combinational-read and one registered-read instance
// driven with identical stimulus.
module tb_ram_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ram_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) b0 ();
  ram_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) b1 ();

  logic       st0, st1;
  logic [7:0] ptr0, ptr1;

  ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_REG(0), .OUT_ADDR(8'hFF), .OUT_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave), .fsm_state(st0), .load_ptr(ptr0));
  ram_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_REG(1), .OUT_ADDR(8'hFF), .OUT_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave), .fsm_state(st1), .load_ptr(ptr1));

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] di, input logic w, input logic o,
                       input logic lv, input logic [7:0] ld, input logic ll);
    b0.addr = a;  b1.addr = a;
    b0.data_in = di;  b1.data_in = di;
    b0.we = w;  b1.we = w;
    b0.oe = o;  b1.oe = o;
    b0.load_valid = lv;  b1.load_valid = lv;
    b0.load_data = ld;  b1.load_data = ld;
    b0.load_last = ll;  b1.load_last = ll;
  endtask

  task automatic idle();
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic load_word(input logic [7:0] d, input logic ll);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, d, ll);
    tick();
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    drive(a, d, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    idle();
  endtask

  // Comb instance must show the word in the same cycle, registered instance after the edge.
  task automatic cpu_read(input string tag, input logic [7:0] a, input logic [7:0] e);
    drive(a, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    check({tag, "_comb"}, b0.data_out, e);
    tick();
    check({tag, "_reg"}, b1.data_out, e);
    idle();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    check("rst_state", {st1, st0}, 2'b00);
    check("rst_ptr", ptr0, 8'h00);
    check("rst_ready", {b1.load_ready, b0.load_ready}, 2'b11);
    check("rst_hold", {b1.cpu_hold, b0.cpu_hold}, 2'b11);
    check("rst_out", b0.out_data, 8'h00);
    check("rst_outv", b0.out_valid, 1'b0);
    check("rst_dout", {b1.data_out, b0.data_out}, 16'h0000);
    reset = 1'b0;

    // Three-word image ending on load_last.
    load_word(8'h0A, 1'b0);
    load_word(8'h0B, 1'b0);
    check("l3_still_load", st0, 1'b0);
    load_word(8'h0C, 1'b1);
    idle();
    check("l3_run", {st1, st0}, 2'b11);
    check("l3_ready", b0.load_ready, 1'b0);
    check("l3_hold", b0.cpu_hold, 1'b0);
    check("l3_ptr", ptr0, 8'd3);
    cpu_read("l3_m0", 8'h00, 8'h0A);
    cpu_read("l3_m1", 8'h01, 8'h0B);
    cpu_read("l3_m2", 8'h02, 8'h0C);

    // Stall: idle cycle between two words must not write or advance.
    do_reset();
    load_word(8'h11, 1'b0);
    drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
    tick();
    check("stall_ptr_idle", ptr0, 8'd1);
    load_word(8'h22, 1'b0);
    idle();
    check("stall_ptr", ptr0, 8'd2);
    check("stall_m0", dut0.mem[0], 8'h11);
    check("stall_m1", dut0.mem[1], 8'h22);
    check("stall_m2", dut0.mem[2], 8'h0C);

    // Full 256-word image with no load_last.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      if (i == 255) begin
        check("full_pre_state", st0, 1'b0);
        check("full_pre_ptr", ptr0, 8'hFF);
      end
      load_word(8'(i), 1'b0);
    end
    check("full_run", {st1, st0}, 2'b11);
    check("full_ptr_nowrap", ptr0, 8'hFF);
    load_word(8'hEE, 1'b0);
    idle();
    check("full_ignore_valid", dut0.mem[0], 8'h00);
    check("full_mem_ff", dut0.mem[255], 8'hFF);
    cpu_read("full_outreg", 8'hFF, 8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h7E);
    cpu_read("full_a00", 8'h00, exp_q.pop_front());
    cpu_read("full_a80", 8'h80, exp_q.pop_front());
    cpu_read("full_a7e", 8'h7E, exp_q.pop_front());

    // Output register write and a plain RAM write.
    cpu_write(8'hFF, 8'h5A);
    check("out_data", b0.out_data, 8'h5A);
    check("out_valid_hi", {b1.out_valid, b0.out_valid}, 2'b11);
    tick();
    check("out_valid_lo", b0.out_valid, 1'b0);
    check("out_ram_kept", dut0.mem[255], 8'hFF);
    cpu_read("out_read", 8'hFF, 8'h5A);
    cpu_write(8'h10, 8'h33);
    cpu_read("ram_10", 8'h10, 8'h33);

    // Back-to-back output writes.
    drive(8'hFF, 8'h61, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("b2b_v1", b0.out_valid, 1'b1);
    drive(8'hFF, 8'h62, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    check("b2b_v2", b0.out_valid, 1'b1);
    check("b2b_data", b0.out_data, 8'h62);
    idle();
    tick();
    check("b2b_v3", b0.out_valid, 1'b0);

    // Simultaneous write and read at 0x20.
    cpu_write(8'h20, 8'h01);
    drive(8'h20, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    check("rw_comb_pre", b0.data_out, 8'h01);
    tick();
    check("rw_reg_old", b1.data_out, 8'h01);
    check("rw_comb_new", b0.data_out, 8'h02);
    drive(8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    check("rw_reg_new", b1.data_out, 8'h02);
    idle();
    tick();
    check("rd_oe_low", b1.data_out, 8'h00);

    // Reset in the middle of a reload.
    do_reset();
    load_word(8'h55, 1'b0);
    load_word(8'h66, 1'b0);
    idle();
    reset = 1'b1;
    tick();
    check("mid_ptr", ptr0, 8'h00);
    check("mid_state", st0, 1'b0);
    check("mid_out", b0.out_data, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      load_word(8'hA0 + 8'(i), (i == 3));
    idle();
    check("mid_ptr4", ptr0, 8'd4);
    check("mid_run", {st1, st0}, 2'b11);
    for (int i = 0; i < 4; i++)
      cpu_read("mid_mem", 8'(i), 8'hA0 + 8'(i));
    cpu_read("mid_persist", 8'h04, 8'h04);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
